roc_decoder: RTL and testbench

ROC_DECODER -- requirements
Module: roc_decoder

---
 rtl/roc_pkg.sv | 37 +++
 rtl/aer_rx_handshake.sv | 83 ++++++++
 rtl/roc_decoder.sv | 163 ++++++++++++++++
 tb/tb_roc_decoder.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/roc_pkg.sv
// ---------------------------------------------------------------------------
// roc_pkg
// Declarations shared by the rank-order-code (ROC) encoder and decoder:
//   - AER address width and the reserved frame-reset word
//   - frame and handshake state encodings
//   - default image geometry
//   - address classification helper
// ---------------------------------------------------------------------------
package roc_pkg;

    localparam int AER_ADDR_W = 10;

    // Sent twice in a row to open a new frame (once to arm, once to start).
    localparam logic [AER_ADDR_W-1:0] AER_RESET_WORD = 10'h1FF;

    localparam int DEFAULT_IMAGE_SIZE      = 256;
    localparam int DEFAULT_PIXEL_MAX_VALUE = 255;

    typedef enum logic [1:0] {
        FS_IDLE,
        FS_ARMED,
        FS_RECEIVE,
        FS_DONE
    } frame_state_e;

    typedef enum logic {
        HS_WAIT_REQ,
        HS_WAIT_LOW
    } hs_state_e;

    // Pixel events carry 2'b00 in the two top address bits; the reset word
    // (2'b01 on top) therefore never decodes as a pixel.
    function automatic logic is_pixel_addr(input logic [AER_ADDR_W-1:0] addr);
        return (addr[AER_ADDR_W-1 -: 2] == 2'b00);
    endfunction

endpackage

// File: rtl/aer_rx_handshake.sv
// ---------------------------------------------------------------------------
// aer_rx_handshake
// Receives AER events over an asynchronous 4-phase REQ/ACK handshake.
// REQ is double-flop synchronized; the address is sampled once the
// synchronized REQ is seen high (it is stable for the whole REQ phase).
// Exactly one event pulse is produced per handshake.
//
// Ports
//   CLK            in   clock, rising edge
//   RST            in   asynchronous, active-high reset
//   req_i          in   AERIN_REQ, asynchronous to CLK
//   addr_i         in   AERIN_ADDR, stable while req_i high
//   ack_o          out  AERIN_ACK (registered)
//   event_valid_o  out  one-cycle pulse, high the cycle after the latch
//   event_addr_o   out  latched event address
// ---------------------------------------------------------------------------
module aer_rx_handshake
    import roc_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  req_i,
    input  logic [AER_ADDR_W-1:0] addr_i,
    output logic                  ack_o,
    output logic                  event_valid_o,
    output logic [AER_ADDR_W-1:0] event_addr_o
);

    logic                  req_s1_q, req_s2_q;
    hs_state_e             state_q, state_d;
    logic                  ack_q, ack_d;
    logic                  evt_q, evt_d;
    logic [AER_ADDR_W-1:0] addr_q, addr_d;

    // Clearing the synchronizer on reset makes a REQ still held high after
    // release look like a fresh rising edge, restarting the full handshake.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            req_s1_q <= 1'b0;
            req_s2_q <= 1'b0;
            state_q  <= HS_WAIT_REQ;
            ack_q    <= 1'b0;
            evt_q    <= 1'b0;
            addr_q   <= '0;
        end else begin
            req_s1_q <= req_i;
            req_s2_q <= req_s1_q;
            state_q  <= state_d;
            ack_q    <= ack_d;
            evt_q    <= evt_d;
            addr_q   <= addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ack_d   = ack_q;
        addr_d  = addr_q;
        evt_d   = 1'b0;
        unique case (state_q)
            HS_WAIT_REQ: begin
                if (req_s2_q) begin
                    addr_d  = addr_i;
                    ack_d   = 1'b1;
                    evt_d   = 1'b1;
                    state_d = HS_WAIT_LOW;
                end
            end
            HS_WAIT_LOW: begin
                if (!req_s2_q) begin
                    ack_d   = 1'b0;
                    state_d = HS_WAIT_REQ;
                end
            end
            default: state_d = HS_WAIT_REQ;
        endcase
    end

    assign ack_o         = ack_q;
    assign event_valid_o = evt_q;
    assign event_addr_o  = addr_q;

endmodule

// File: rtl/roc_decoder.sv
// ---------------------------------------------------------------------------
// roc_decoder
// Rebuilds an intensity image from a rank-order-coded AER spike stream.
// The n-th distinct pixel to fire in a frame (n counted from 0) is given
// intensity PIXEL_MAX_VALUE - n; pixels that never fire read 0.
// A frame opens with two reset words (IDLE -> ARMED -> RECEIVE) and closes
// when every pixel has fired or FRAME_END is raised.
//
// Ports
//   CLK            in   clock, rising edge
//   RST            in   asynchronous, active-high reset
//   AERIN_ADDR     in   AER event address
//   AERIN_REQ      in   4-phase request (asynchronous)
//   AERIN_ACK      out  4-phase acknowledge
//   FRAME_END      in   level, ends the frame early while receiving
//   DECODED_IMAGE  out  reconstructed intensities, one per pixel
//   IMAGE_VALID    out  image complete and frozen
//   RX_COUNT       out  distinct pixel events accepted this frame
//   DUP_ERR        out  sticky, a pixel fired twice in this frame
//   DECODER_BUSY   out  frame armed or being received
// ---------------------------------------------------------------------------
module roc_decoder
    import roc_pkg::*;
#(
    parameter int IMAGE_SIZE      = DEFAULT_IMAGE_SIZE,
    parameter int IMAGE_SIZE_BITS = $clog2(IMAGE_SIZE),
    parameter int PIXEL_MAX_VALUE = DEFAULT_PIXEL_MAX_VALUE,
    parameter int PIXEL_BITS      = $clog2(PIXEL_MAX_VALUE)
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [AER_ADDR_W-1:0]  AERIN_ADDR,
    input  logic                   AERIN_REQ,
    output logic                   AERIN_ACK,
    input  logic                   FRAME_END,
    output logic [PIXEL_BITS-1:0]  DECODED_IMAGE [0:IMAGE_SIZE-1],
    output logic                   IMAGE_VALID,
    output logic [IMAGE_SIZE_BITS:0] RX_COUNT,
    output logic                   DUP_ERR,
    output logic                   DECODER_BUSY
);

    localparam logic [IMAGE_SIZE_BITS:0] FULL_CNT = (IMAGE_SIZE_BITS+1)'(IMAGE_SIZE);
    localparam logic [IMAGE_SIZE_BITS:0] CNT_ONE  = (IMAGE_SIZE_BITS+1)'(1);
    localparam logic [PIXEL_BITS:0]      PMAX_W   = (PIXEL_BITS+1)'(PIXEL_MAX_VALUE);

    // ---------------------------------------------------------------- AER rx
    logic                  evt_valid;
    logic [AER_ADDR_W-1:0] evt_addr;

    aer_rx_handshake u_rx (
        .CLK           (CLK),
        .RST           (RST),
        .req_i         (AERIN_REQ),
        .addr_i        (AERIN_ADDR),
        .ack_o         (AERIN_ACK),
        .event_valid_o (evt_valid),
        .event_addr_o  (evt_addr)
    );

    // ------------------------------------------------------------ decode
    logic                       is_rst_word, is_pixel;
    logic [IMAGE_SIZE_BITS-1:0] pix_idx;

    assign is_rst_word = evt_valid && (evt_addr == AER_RESET_WORD);
    assign is_pixel    = evt_valid && is_pixel_addr(evt_addr);
    assign pix_idx     = evt_addr[IMAGE_SIZE_BITS-1:0];

    // ------------------------------------------------------------- state
    frame_state_e               state_q, state_d;
    logic [IMAGE_SIZE_BITS:0]   rx_count_q, rx_count_d;
    logic                       dup_q, dup_d;
    logic [IMAGE_SIZE-1:0]      seen_q;
    logic [PIXEL_BITS-1:0]      image_q [0:IMAGE_SIZE-1];

    logic                       clr_frame;
    logic                       wr_en;
    logic [PIXEL_BITS-1:0]      wr_val;
    logic [PIXEL_BITS:0]        cnt_ext;

    // Rank-to-intensity in one extra bit so an out-of-range rank clamps to 0
    // instead of wrapping to a bright value.
    assign cnt_ext = (PIXEL_BITS+1)'(rx_count_q);
    assign wr_val  = (cnt_ext > PMAX_W) ? '0 : PIXEL_BITS'(PMAX_W - cnt_ext);

    always_comb begin
        state_d    = state_q;
        rx_count_d = rx_count_q;
        dup_d      = dup_q;
        clr_frame  = 1'b0;
        wr_en      = 1'b0;
        unique case (state_q)
            FS_IDLE: begin
                if (is_rst_word) state_d = FS_ARMED;
            end
            FS_ARMED: begin
                if (is_rst_word) begin
                    state_d    = FS_RECEIVE;
                    clr_frame  = 1'b1;
                    rx_count_d = '0;
                    dup_d      = 1'b0;
                end else if (is_pixel) begin
                    // A lone reset word followed by data is treated as noise.
                    state_d = FS_IDLE;
                end
            end
            FS_RECEIVE: begin
                if (is_rst_word) begin
                    state_d = FS_ARMED;
                end else begin
                    if (is_pixel) begin
                        if (seen_q[pix_idx]) begin
                            dup_d = 1'b1;
                        end else if (rx_count_q < FULL_CNT) begin
                            wr_en      = 1'b1;
                            rx_count_d = rx_count_q + CNT_ONE;
                        end
                    end
                    // Uses the post-event count so a coincident event is
                    // recorded before the frame closes.
                    if ((rx_count_d == FULL_CNT) || FRAME_END) state_d = FS_DONE;
                end
            end
            FS_DONE: begin
                if (is_rst_word) state_d = FS_ARMED;
            end
            default: state_d = FS_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= FS_IDLE;
            rx_count_q <= '0;
            dup_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rx_count_q <= rx_count_d;
            dup_q      <= dup_d;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            seen_q <= '0;
            for (int i = 0; i < IMAGE_SIZE; i++) image_q[i] <= '0;
        end else if (clr_frame) begin
            seen_q <= '0;
            for (int i = 0; i < IMAGE_SIZE; i++) image_q[i] <= '0;
        end else if (wr_en) begin
            seen_q[pix_idx]  <= 1'b1;
            image_q[pix_idx] <= wr_val;
        end
    end

    // ----------------------------------------------------------- outputs
    assign DECODED_IMAGE = image_q;
    assign IMAGE_VALID   = (state_q == FS_DONE);
    assign DECODER_BUSY  = (state_q == FS_ARMED) || (state_q == FS_RECEIVE);
    assign RX_COUNT      = rx_count_q;
    assign DUP_ERR       = dup_q;

endmodule

// File: tb/tb_roc_decoder.sv
module tb_roc_decoder;

    logic       CLK = 1'b0;
    logic       RST;
    logic [9:0] AERIN_ADDR;
    logic       AERIN_REQ;
    logic       AERIN_ACK;
    logic       FRAME_END;
    logic [7:0] DECODED_IMAGE [0:255];
    logic       IMAGE_VALID;
    logic [8:0] RX_COUNT;
    logic       DUP_ERR;
    logic       DECODER_BUSY;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    roc_decoder dut (
        .CLK           (CLK),
        .RST           (RST),
        .AERIN_ADDR    (AERIN_ADDR),
        .AERIN_REQ     (AERIN_REQ),
        .AERIN_ACK     (AERIN_ACK),
        .FRAME_END     (FRAME_END),
        .DECODED_IMAGE (DECODED_IMAGE),
        .IMAGE_VALID   (IMAGE_VALID),
        .RX_COUNT      (RX_COUNT),
        .DUP_ERR       (DUP_ERR),
        .DECODER_BUSY  (DECODER_BUSY)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    // One full 4-phase handshake; ok=0 if ACK failed to rise or fall in time.
    task automatic send_event(input logic [9:0] a, output bit ok);
        int t;
        ok = 1'b1;
        @(negedge CLK);
        AERIN_ADDR = a;
        AERIN_REQ  = 1'b1;
        t = 0;
        while (AERIN_ACK !== 1'b1 && t < 20) begin @(negedge CLK); t++; end
        if (AERIN_ACK !== 1'b1) ok = 1'b0;
        AERIN_REQ = 1'b0;
        t = 0;
        while (AERIN_ACK !== 1'b0 && t < 20) begin @(negedge CLK); t++; end
        if (AERIN_ACK !== 1'b0) ok = 1'b0;
        repeat (2) @(negedge CLK);
    endtask

    function automatic int nonzero_except(input int a, input int b, input int c);
        int n = 0;
        for (int i = 0; i < 256; i++)
            if (i != a && i != b && i != c && DECODED_IMAGE[i] !== 8'd0) n++;
        return n;
    endfunction

    task automatic test_reset();
        RST = 1'b1; AERIN_REQ = 1'b0; AERIN_ADDR = '0; FRAME_END = 1'b0;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        n_cmp++; if (AERIN_ACK !== 1'b0) begin n_bad++; $display("FAIL reset_ack got=%b want=0", AERIN_ACK); end
        n_cmp++; if (IMAGE_VALID !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b want=0", IMAGE_VALID); end
        n_cmp++; if (DECODER_BUSY !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b want=0", DECODER_BUSY); end
        n_cmp++; if (RX_COUNT !== 9'd0) begin n_bad++; $display("FAIL reset_rx got=%0d want=0", RX_COUNT); end
        n_cmp++; if (DUP_ERR !== 1'b0) begin n_bad++; $display("FAIL reset_dup got=%b want=0", DUP_ERR); end
        n_cmp++; if (nonzero_except(-1, -1, -1) != 0) begin n_bad++; $display("FAIL reset_image nonzero=%0d want=0", nonzero_except(-1, -1, -1)); end
    endtask

    task automatic test_basic();
        bit ok, all_ok;
        all_ok = 1'b1;
        send_event(10'h1FF, ok); all_ok &= ok;
        send_event(10'h1FF, ok); all_ok &= ok;
        send_event(10'd5, ok);   all_ok &= ok;
        send_event(10'd9, ok);   all_ok &= ok;
        send_event(10'd2, ok);   all_ok &= ok;
        n_cmp++; if (!all_ok) begin n_bad++; $display("FAIL basic_handshake got=0 want=1"); end
        n_cmp++; if (DECODED_IMAGE[5] !== 8'd255) begin n_bad++; $display("FAIL basic_img5 got=%0d want=255", DECODED_IMAGE[5]); end
        n_cmp++; if (DECODED_IMAGE[9] !== 8'd254) begin n_bad++; $display("FAIL basic_img9 got=%0d want=254", DECODED_IMAGE[9]); end
        n_cmp++; if (DECODED_IMAGE[2] !== 8'd253) begin n_bad++; $display("FAIL basic_img2 got=%0d want=253", DECODED_IMAGE[2]); end
        n_cmp++; if (nonzero_except(5, 9, 2) != 0) begin n_bad++; $display("FAIL basic_others nonzero=%0d want=0", nonzero_except(5, 9, 2)); end
        n_cmp++; if (RX_COUNT !== 9'd3) begin n_bad++; $display("FAIL basic_rx got=%0d want=3", RX_COUNT); end
        n_cmp++; if (IMAGE_VALID !== 1'b0) begin n_bad++; $display("FAIL basic_valid got=%b want=0", IMAGE_VALID); end
        n_cmp++; if (DECODER_BUSY !== 1'b1) begin n_bad++; $display("FAIL basic_busy got=%b want=1", DECODER_BUSY); end
    endtask

    task automatic test_full_frame();
        bit ok, all_ok;
        int bad;
        all_ok = 1'b1;
        send_event(10'h1FF, ok); all_ok &= ok;   // RECEIVE -> ARMED
        send_event(10'h1FF, ok); all_ok &= ok;   // ARMED -> RECEIVE, cleared
        for (int k = 0; k < 256; k++) begin
            send_event({2'b00, 8'(k)}, ok); all_ok &= ok;
        end
        n_cmp++; if (!all_ok) begin n_bad++; $display("FAIL full_handshake got=0 want=1"); end
        n_cmp++; if (IMAGE_VALID !== 1'b1) begin n_bad++; $display("FAIL full_valid got=%b want=1", IMAGE_VALID); end
        bad = 0;
        for (int k = 0; k < 256; k++) if (DECODED_IMAGE[k] !== 8'(255 - k)) bad++;
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL full_image wrong_pixels=%0d want=0", bad); end
        n_cmp++; if (DUP_ERR !== 1'b0) begin n_bad++; $display("FAIL full_dup got=%b want=0", DUP_ERR); end
        n_cmp++; if (RX_COUNT !== 9'd256) begin n_bad++; $display("FAIL full_rx got=%0d want=256", RX_COUNT); end
        n_cmp++; if (DECODER_BUSY !== 1'b0) begin n_bad++; $display("FAIL full_busy got=%b want=0", DECODER_BUSY); end
        // Pixel in DONE is ignored: count saturated, image frozen.
        send_event(10'd17, ok);
        n_cmp++; if (RX_COUNT !== 9'd256) begin n_bad++; $display("FAIL done_rx got=%0d want=256", RX_COUNT); end
        n_cmp++; if (DECODED_IMAGE[17] !== 8'd238) begin n_bad++; $display("FAIL done_img17 got=%0d want=238", DECODED_IMAGE[17]); end
        n_cmp++; if (IMAGE_VALID !== 1'b1) begin n_bad++; $display("FAIL done_valid got=%b want=1", IMAGE_VALID); end
    endtask

    task automatic test_dup();
        bit ok, all_ok;
        all_ok = 1'b1;
        send_event(10'h1FF, ok); all_ok &= ok;   // DONE -> ARMED
        send_event(10'h1FF, ok); all_ok &= ok;   // ARMED -> RECEIVE
        send_event(10'd7, ok);   all_ok &= ok;
        send_event(10'd7, ok);   all_ok &= ok;
        n_cmp++; if (!all_ok) begin n_bad++; $display("FAIL dup_handshake got=0 want=1"); end
        n_cmp++; if (DECODED_IMAGE[7] !== 8'd255) begin n_bad++; $display("FAIL dup_img7 got=%0d want=255", DECODED_IMAGE[7]); end
        n_cmp++; if (nonzero_except(7, -1, -1) != 0) begin n_bad++; $display("FAIL dup_others nonzero=%0d want=0", nonzero_except(7, -1, -1)); end
        n_cmp++; if (RX_COUNT !== 9'd1) begin n_bad++; $display("FAIL dup_rx got=%0d want=1", RX_COUNT); end
        n_cmp++; if (DUP_ERR !== 1'b1) begin n_bad++; $display("FAIL dup_flag got=%b want=1", DUP_ERR); end
        send_event(10'h1FF, ok);                  // abort -> ARMED, flag sticky
        n_cmp++; if (DUP_ERR !== 1'b1) begin n_bad++; $display("FAIL dup_sticky got=%b want=1", DUP_ERR); end
        n_cmp++; if (DECODER_BUSY !== 1'b1 || IMAGE_VALID !== 1'b0) begin n_bad++; $display("FAIL abort_state busy=%b valid=%b want busy=1 valid=0", DECODER_BUSY, IMAGE_VALID); end
        send_event(10'h1FF, ok);                  // new frame clears
        n_cmp++; if (DUP_ERR !== 1'b0) begin n_bad++; $display("FAIL dup_clear got=%b want=0", DUP_ERR); end
        n_cmp++; if (RX_COUNT !== 9'd0) begin n_bad++; $display("FAIL dup_rx_clear got=%0d want=0", RX_COUNT); end
        n_cmp++; if (DECODED_IMAGE[7] !== 8'd0) begin n_bad++; $display("FAIL dup_img_clear got=%0d want=0", DECODED_IMAGE[7]); end
    endtask

    task automatic test_frame_end();
        bit ok, all_ok;
        all_ok = 1'b1;
        send_event(10'h1FF, ok); all_ok &= ok;   // RECEIVE -> ARMED
        send_event(10'h1FF, ok); all_ok &= ok;   // ARMED -> RECEIVE
        for (int k = 20; k < 30; k++) begin
            send_event(10'(k), ok); all_ok &= ok;
        end
        n_cmp++; if (!all_ok) begin n_bad++; $display("FAIL fe_handshake got=0 want=1"); end
        n_cmp++; if (IMAGE_VALID !== 1'b0) begin n_bad++; $display("FAIL fe_valid_before got=%b want=0", IMAGE_VALID); end
        @(negedge CLK); FRAME_END = 1'b1;
        repeat (2) @(negedge CLK);
        n_cmp++; if (IMAGE_VALID !== 1'b1) begin n_bad++; $display("FAIL fe_valid got=%b want=1", IMAGE_VALID); end
        n_cmp++; if (RX_COUNT !== 9'd10) begin n_bad++; $display("FAIL fe_rx got=%0d want=10", RX_COUNT); end
        n_cmp++; if (DECODED_IMAGE[20] !== 8'd255) begin n_bad++; $display("FAIL fe_img20 got=%0d want=255", DECODED_IMAGE[20]); end
        n_cmp++; if (DECODED_IMAGE[29] !== 8'd246) begin n_bad++; $display("FAIL fe_img29 got=%0d want=246", DECODED_IMAGE[29]); end
        FRAME_END = 1'b0;
    endtask

    task automatic test_latency();
        int n;
        @(negedge CLK);
        AERIN_ADDR = 10'd40;
        AERIN_REQ  = 1'b1;
        n = 0;
        do begin @(posedge CLK); #1; n++; end while (AERIN_ACK !== 1'b1 && n < 20);
        n_cmp++; if (n != 3 || AERIN_ACK !== 1'b1) begin n_bad++; $display("FAIL lat_rise edges=%0d want=3", n); end
        @(negedge CLK);
        AERIN_REQ = 1'b0;
        n = 0;
        do begin @(posedge CLK); #1; n++; end while (AERIN_ACK !== 1'b0 && n < 20);
        n_cmp++; if (n != 3 || AERIN_ACK !== 1'b0) begin n_bad++; $display("FAIL lat_fall edges=%0d want=3", n); end
        repeat (2) @(negedge CLK);
        n_cmp++; if (RX_COUNT !== 9'd10 || DECODED_IMAGE[40] !== 8'd0 || IMAGE_VALID !== 1'b1)
            begin n_bad++; $display("FAIL lat_done_drop rx=%0d img40=%0d valid=%b want 10/0/1", RX_COUNT, DECODED_IMAGE[40], IMAGE_VALID); end
    endtask

    task automatic test_arm_drop();
        bit ok, all_ok;
        all_ok = 1'b1;
        send_event(10'h1FF, ok); all_ok &= ok;   // DONE -> ARMED
        n_cmp++; if (IMAGE_VALID !== 1'b0 || DECODER_BUSY !== 1'b1) begin n_bad++; $display("FAIL arm_state valid=%b busy=%b want 0/1", IMAGE_VALID, DECODER_BUSY); end
        send_event(10'd3, ok);   all_ok &= ok;   // ARMED -> IDLE
        n_cmp++; if (DECODER_BUSY !== 1'b0) begin n_bad++; $display("FAIL arm_idle busy=%b want=0", DECODER_BUSY); end
        n_cmp++; if (DECODED_IMAGE[3] !== 8'd0 || DECODED_IMAGE[20] !== 8'd255) begin n_bad++; $display("FAIL arm_image img3=%0d img20=%0d want 0/255", DECODED_IMAGE[3], DECODED_IMAGE[20]); end
        send_event(10'd3, ok);   all_ok &= ok;   // IDLE: dropped, still acked
        send_event(10'h300, ok); all_ok &= ok;   // non-pixel, non-reset
        n_cmp++; if (!all_ok) begin n_bad++; $display("FAIL arm_handshake got=0 want=1"); end
        n_cmp++; if (DECODER_BUSY !== 1'b0 || DECODED_IMAGE[3] !== 8'd0 || RX_COUNT !== 9'd10)
            begin n_bad++; $display("FAIL idle_drop busy=%b img3=%0d rx=%0d want 0/0/10", DECODER_BUSY, DECODED_IMAGE[3], RX_COUNT); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int n;
        send_event(10'h1FF, ok);                  // IDLE -> ARMED
        send_event(10'h1FF, ok);                  // ARMED -> RECEIVE
        send_event(10'd1, ok);
        n_cmp++; if (DECODED_IMAGE[1] !== 8'd255 || RX_COUNT !== 9'd1) begin n_bad++; $display("FAIL pre_rst img1=%0d rx=%0d want 255/1", DECODED_IMAGE[1], RX_COUNT); end
        @(negedge CLK);
        AERIN_ADDR = 10'h1FF;
        AERIN_REQ  = 1'b1;
        n = 0;
        while (AERIN_ACK !== 1'b1 && n < 20) begin @(negedge CLK); n++; end
        n_cmp++; if (AERIN_ACK !== 1'b1) begin n_bad++; $display("FAIL rst_mid_ack_up got=%b want=1", AERIN_ACK); end
        RST = 1'b1;
        #1;
        n_cmp++; if (AERIN_ACK !== 1'b0) begin n_bad++; $display("FAIL rst_mid_ack got=%b want=0", AERIN_ACK); end
        n_cmp++; if (DECODER_BUSY !== 1'b0 || RX_COUNT !== 9'd0 || DECODED_IMAGE[1] !== 8'd0)
            begin n_bad++; $display("FAIL rst_mid_state busy=%b rx=%0d img1=%0d want 0/0/0", DECODER_BUSY, RX_COUNT, DECODED_IMAGE[1]); end
        @(negedge CLK);
        RST = 1'b0;
        n = 0;
        do begin @(posedge CLK); #1; n++; end while (AERIN_ACK !== 1'b1 && n < 20);
        n_cmp++; if (n != 3 || AERIN_ACK !== 1'b1) begin n_bad++; $display("FAIL rst_rerise edges=%0d want=3", n); end
        repeat (2) @(negedge CLK);
        // Re-requested reset word takes IDLE -> ARMED.
        n_cmp++; if (DECODER_BUSY !== 1'b1) begin n_bad++; $display("FAIL rst_new_event busy=%b want=1", DECODER_BUSY); end
        AERIN_REQ = 1'b0;
        n = 0;
        while (AERIN_ACK !== 1'b0 && n < 20) begin @(negedge CLK); n++; end
        n_cmp++; if (AERIN_ACK !== 1'b0) begin n_bad++; $display("FAIL rst_ack_fall got=%b want=0", AERIN_ACK); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full_frame();
        test_dup();
        test_frame_end();
        test_latency();
        test_arm_drop();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
